// File: rtl/box_ctrl.sv
// box_ctrl: accepts clamped face detections and commits the latest one to the
// box overlay at frame boundaries, hiding the box after HOLD_FRAMES empty frames.
`default_nettype none

module box_ctrl #(
  parameter int IMG_WIDTH   = 768,
  parameter int IMG_HEIGHT  = 576,
  parameter int HOLD_FRAMES = 8,
  parameter int MIN_SIZE    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic       det_valid,
  output logic       det_ready,
  input  logic       det_none,
  input  logic [9:0] det_x,
  input  logic [9:0] det_y,
  input  logic [9:0] det_w,
  input  logic [9:0] det_h,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [9:0] box_width,
  output logic [9:0] box_height,
  output logic       box_en,
  output logic       frame_end,
  output logic [1:0] state
);

  localparam int MISS_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [9:0]  X_END = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]  Y_END = 10'(IMG_HEIGHT - 1);
  localparam logic [10:0] MIN_S = 11'(MIN_SIZE);
  localparam logic [10:0] W_MAX = 11'(IMG_WIDTH - 2);
  localparam logic [10:0] H_MAX = 11'(IMG_HEIGHT - 2);
  localparam logic [10:0] X_LIM = 11'(IMG_WIDTH - 1);
  localparam logic [10:0] Y_LIM = 11'(IMG_HEIGHT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(HOLD_FRAMES - 1);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t cur_state, nxt_state;

  logic [9:0]        x_cnt, y_cnt;
  logic              last_pix;
  logic              pend_full, pend_none;
  logic [9:0]        pend_x, pend_y, pend_w, pend_h;
  logic [MISS_W-1:0] miss_cnt, nxt_miss;
  logic              nxt_en, load_box;
  logic [10:0]       clamp_w, clamp_h, clamp_x, clamp_y;

  function automatic logic [10:0] clamp_size(input logic [10:0] v, input logic [10:0] hi);
    logic [10:0] r;
    r = (v < MIN_S) ? MIN_S : ((v > hi) ? hi : v);
    return {r[10:1], 1'b0};
  endfunction

  // Keeps the centre at least half a box away from both image edges.
  function automatic logic [10:0] clamp_pos(input logic [10:0] p, input logic [10:0] half,
                                            input logic [10:0] lim);
    logic [10:0] r;
    r = (p < half) ? half : p;
    r = (r > lim - half) ? (lim - half) : r;
    return r;
  endfunction

  always_comb begin
    clamp_w = clamp_size({1'b0, det_w}, W_MAX);
    clamp_h = clamp_size({1'b0, det_h}, H_MAX);
    clamp_x = clamp_pos({1'b0, det_x}, clamp_w >> 1, X_LIM);
    clamp_y = clamp_pos({1'b0, det_y}, clamp_h >> 1, Y_LIM);
  end

  assign last_pix  = pix_valid && (x_cnt == X_END) && (y_cnt == Y_END);
  assign det_ready = !last_pix;
  assign state     = cur_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pix_valid) begin
      if (x_cnt == X_END) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_END) ? '0 : y_cnt + 10'd1;
      end else begin
        x_cnt <= x_cnt + 10'd1;
      end
    end
  end

  // Transfers cannot coincide with the commit cycle since det_ready is low then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_none <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_w    <= '0;
      pend_h    <= '0;
    end else if (det_valid && det_ready) begin
      pend_full <= 1'b1;
      pend_none <= det_none;
      if (!det_none) begin
        pend_x <= clamp_x[9:0];
        pend_y <= clamp_y[9:0];
        pend_w <= clamp_w[9:0];
        pend_h <= clamp_h[9:0];
      end
    end else if (last_pix) begin
      pend_full <= 1'b0;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_miss  = miss_cnt;
    nxt_en    = box_en;
    load_box  = 1'b0;
    if (last_pix) begin
      if (pend_full && !pend_none) begin
        load_box  = 1'b1;
        nxt_en    = 1'b1;
        nxt_state = SHOW;
        nxt_miss  = '0;
      end else if (pend_full) begin
        nxt_en    = 1'b0;
        nxt_state = IDLE;
        nxt_miss  = '0;
      end else begin
        case (cur_state)
          SHOW: begin
            if (HOLD_FRAMES == 1) begin
              nxt_en    = 1'b0;
              nxt_state = IDLE;
              nxt_miss  = '0;
            end else begin
              nxt_state = HOLD;
              nxt_miss  = MISS_ONE;
            end
          end
          HOLD: begin
            if (miss_cnt == MISS_LAST) begin
              nxt_en    = 1'b0;
              nxt_state = IDLE;
              nxt_miss  = '0;
            end else begin
              nxt_miss = miss_cnt + MISS_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= IDLE;
      miss_cnt   <= '0;
      box_en     <= 1'b0;
      frame_end  <= 1'b0;
      box_x      <= '0;
      box_y      <= '0;
      box_width  <= '0;
      box_height <= '0;
    end else begin
      cur_state <= nxt_state;
      miss_cnt  <= nxt_miss;
      box_en    <= nxt_en;
      frame_end <= last_pix;
      if (load_box) begin
        box_x      <= pend_x;
        box_y      <= pend_y;
        box_width  <= pend_w;
        box_height <= pend_h;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_box_ctrl.sv
// tb_box_ctrl: directed, table-driven bench for box_ctrl on a reduced 40x30 image.
`default_nettype none

module tb_box_ctrl;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int HF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic       det_valid = 1'b0;
  logic       det_none = 1'b0;
  logic [9:0] det_x = '0, det_y = '0, det_w = '0, det_h = '0;

  logic       det_ready, box_en, frame_end;
  logic [9:0] box_x, box_y, box_width, box_height;
  logic [1:0] state;

  logic       det_ready1, box_en1, frame_end1;
  logic [9:0] box_x1, box_y1, box_width1, box_height1;
  logic [1:0] state1;

  box_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HOLD_FRAMES(HF), .MIN_SIZE(4)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid),
    .det_valid(det_valid), .det_ready(det_ready), .det_none(det_none),
    .det_x(det_x), .det_y(det_y), .det_w(det_w), .det_h(det_h),
    .box_x(box_x), .box_y(box_y), .box_width(box_width), .box_height(box_height),
    .box_en(box_en), .frame_end(frame_end), .state(state)
  );

  box_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HOLD_FRAMES(1), .MIN_SIZE(4)) dut1 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid),
    .det_valid(det_valid), .det_ready(det_ready1), .det_none(det_none),
    .det_x(det_x), .det_y(det_y), .det_w(det_w), .det_h(det_h),
    .box_x(box_x1), .box_y(box_y1), .box_width(box_width1), .box_height(box_height1),
    .box_en(box_en1), .frame_end(frame_end1), .state(state1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference pixel position of the pixel offered in the current cycle.
  int px = 0;
  int py = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      px <= 0;
      py <= 0;
    end else if (pix_valid) begin
      if (px == W - 1) begin
        px <= 0;
        py <= (py == H - 1) ? 0 : py + 1;
      end else begin
        px <= px + 1;
      end
    end
  end

  typedef struct {
    logic [9:0] x, y, w, h;
    logic [9:0] ex, ey, ew, eh;
  } vec_t;
  vec_t vt[6];

  logic [9:0] cx = '0, cy = '0, cw = '0, ch = '0;
  logic       cen = 1'b0;
  logic [1:0] cst = 2'd0;
  logic [9:0] nx, ny, nw, nh;
  logic       nen;
  logic [1:0] nst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_box(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] w, input logic [9:0] h, input logic en,
                         input logic [1:0] st);
    chk({tag, ".box_x"}, box_x, x);
    chk({tag, ".box_y"}, box_y, y);
    chk({tag, ".box_width"}, box_width, w);
    chk({tag, ".box_height"}, box_height, h);
    chk({tag, ".box_en"}, box_en, en);
    chk({tag, ".state"}, state, st);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pix_valid = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_next(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                          input logic [9:0] h, input logic en, input logic [1:0] st);
    nx = x; ny = y; nw = w; nh = h; nen = en; nst = st;
  endtask

  task automatic offer(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                       input logic [9:0] h, input logic none);
    det_x = x; det_y = y; det_w = w; det_h = h; det_none = none;
    det_valid = 1'b1;
    #1;
    chk("offer.det_ready", det_ready, 1);
    @(posedge clk);
    #1;
    det_valid = 1'b0;
    det_none  = 1'b0;
  endtask

  // Runs to the last pixel L, checks outputs are frozen there, then checks the commit at L+1.
  task automatic finish_frame(input string tag, input logic hold_det);
    int n;
    n = 0;
    while (!(pix_valid && px == W - 1 && py == H - 1) && n < 3 * W * H) begin
      step();
      n++;
    end
    if (n >= 3 * W * H) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no last pixel within %0d cycles", tag, n);
      return;
    end
    if (hold_det) det_valid = 1'b1;
    #1;
    chk({tag, ".L.det_ready"}, det_ready, 0);
    chk({tag, ".L.frame_end"}, frame_end, 0);
    chk_box({tag, ".L"}, cx, cy, cw, ch, cen, cst);
    @(posedge clk);
    #1;
    chk({tag, ".L1.frame_end"}, frame_end, 1);
    chk_box({tag, ".L1"}, nx, ny, nw, nh, nen, nst);
    cx = nx; cy = ny; cw = nw; ch = nh; cen = nen; cst = nst;
    if (hold_det) begin
      chk({tag, ".L1.det_ready"}, det_ready, 1);
      @(posedge clk);
      #1;
      det_valid = 1'b0;
    end else begin
      step();
    end
    chk({tag, ".L2.frame_end"}, frame_end, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{x:10'd20,   y:10'd15, w:10'd10,  h:10'd8,    ex:10'd20, ey:10'd15, ew:10'd10, eh:10'd8};
    vt[1] = '{x:10'd2,    y:10'd1,  w:10'd11,  h:10'd7,    ex:10'd5,  ey:10'd3,  ew:10'd10, eh:10'd6};
    vt[2] = '{x:10'd39,   y:10'd29, w:10'd900, h:10'd3,    ex:10'd20, ey:10'd27, ew:10'd38, eh:10'd4};
    vt[3] = '{x:10'd1000, y:10'd0,  w:10'd0,   h:10'd1023, ex:10'd37, ey:10'd14, ew:10'd4,  eh:10'd28};
    vt[4] = '{x:10'd0,    y:10'd29, w:10'd38,  h:10'd29,   ex:10'd19, ey:10'd15, ew:10'd38, eh:10'd28};
    vt[5] = '{x:10'd7,    y:10'd9,  w:10'd5,   h:10'd5,    ex:10'd7,  ey:10'd9,  ew:10'd4,  eh:10'd4};

    reset = 1'b1;
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_box("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.frame_end", frame_end, 0);
    chk("reset.det_ready", det_ready, 1);
    reset = 1'b0;

    // First detection, committed only at the frame boundary.
    repeat (500) step();
    offer(10'd20, 10'd15, 10'd10, 10'd8, 1'b0);
    set_next(10'd20, 10'd15, 10'd10, 10'd8, 1'b1, 2'd1);
    finish_frame("first", 1'b0);

    for (int i = 0; i < 6; i++) begin
      repeat (50 + i * 40) step();
      offer(vt[i].x, vt[i].y, vt[i].w, vt[i].h, 1'b0);
      set_next(vt[i].ex, vt[i].ey, vt[i].ew, vt[i].eh, 1'b1, 2'd1);
      finish_frame($sformatf("clamp%0d", i), 1'b0);
    end

    // Latest of two detections in one frame wins.
    repeat (30) step();
    offer(10'd10, 10'd10, 10'd6, 10'd6, 1'b0);
    repeat (200) step();
    offer(10'd25, 10'd20, 10'd12, 10'd8, 1'b0);
    set_next(10'd25, 10'd20, 10'd12, 10'd8, 1'b1, 2'd1);
    finish_frame("latest", 1'b0);

    // Asynchronous reset in mid-frame.
    repeat (300) step();
    #2;
    reset = 1'b1;
    #1;
    chk_box("midreset", 0, 0, 0, 0, 0, 0);
    chk("midreset.frame_end", frame_end, 0);
    chk("midreset.det_ready", det_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cx = '0; cy = '0; cw = '0; ch = '0; cen = 1'b0; cst = 2'd0;
    repeat (100) step();
    offer(10'd30, 10'd12, 10'd20, 10'd10, 1'b0);
    set_next(10'd29, 10'd12, 10'd20, 10'd10, 1'b1, 2'd1);
    finish_frame("afterreset", 1'b0);

    // Hold for HF empty frames, then hide.
    for (int f = 1; f <= HF; f++) begin
      set_next(10'd29, 10'd12, 10'd20, 10'd10, (f < HF), (f < HF) ? 2'd2 : 2'd0);
      finish_frame($sformatf("hold%0d", f), 1'b0);
      if (f == 1) begin
        chk("hold1.dut1.state", state1, 0);
        chk("hold1.dut1.box_en", box_en1, 0);
      end
    end

    set_next(cx, cy, cw, ch, 1'b0, 2'd0);
    finish_frame("idle_empty", 1'b0);

    // Detection held from the commit cycle transfers one cycle later.
    det_x = 10'd5; det_y = 10'd20; det_w = 10'd8; det_h = 10'd12; det_none = 1'b0;
    set_next(cx, cy, cw, ch, 1'b0, 2'd0);
    finish_frame("held_at_L", 1'b1);
    set_next(10'd5, 10'd20, 10'd8, 10'd12, 1'b1, 2'd1);
    finish_frame("held_commit", 1'b0);

    // "No face" report hides the box but keeps its coordinates.
    repeat (100) step();
    offer(10'd0, 10'd0, 10'd0, 10'd0, 1'b1);
    set_next(10'd5, 10'd20, 10'd8, 10'd12, 1'b0, 2'd0);
    finish_frame("none", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
